// File: rtl/mux_scan_n_if.sv
// mux_scan_n_if: channel inputs, select/mode controls and the registered output handshake of mux_scan_n.
// Ports: I (N_CH*W packed lanes), S, MODE, EN, OUT_RDY toward the mux; OUT_DATA, OUT_CH, OUT_VLD back.
// Optional: MUX_SCAN_PARITY_EN adds OUT_PAR (even parity of OUT_DATA).
interface mux_scan_n_if #(
    parameter int N_CH = 8,
    parameter int W    = 8
);
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH*W-1:0] I;
    logic [SEL_W-1:0]  S;
    logic              MODE;
    logic              EN;
    logic              OUT_RDY;
    logic [W-1:0]      OUT_DATA;
    logic [SEL_W-1:0]  OUT_CH;
    logic              OUT_VLD;
`ifdef MUX_SCAN_PARITY_EN
    logic              OUT_PAR;

    modport master (output I, S, MODE, EN, OUT_RDY,
                    input  OUT_DATA, OUT_CH, OUT_VLD, OUT_PAR);
    modport slave  (input  I, S, MODE, EN, OUT_RDY,
                    output OUT_DATA, OUT_CH, OUT_VLD, OUT_PAR);
`else
    modport master (output I, S, MODE, EN, OUT_RDY,
                    input  OUT_DATA, OUT_CH, OUT_VLD);
    modport slave  (input  I, S, MODE, EN, OUT_RDY,
                    output OUT_DATA, OUT_CH, OUT_VLD);
`endif
endinterface

// File: rtl/mux_scan_n.sv
// mux_scan_n: N_CH x W-bit mux with registered output; manual select (S) or auto-scan dwelling DWELL samples per channel.
// Latency: 1 cycle from accepted EN to OUT_VLD; 1 sample/cycle when OUT_RDY stays high.
// Backpressure: while OUT_VLD && !OUT_RDY the output holds and EN is ignored (no capture, no pointer movement).
// Ports: CLK, RST_N (async active-low), bus (mux_scan_n_if.slave): I, S, MODE, EN, OUT_RDY in; OUT_DATA, OUT_CH, OUT_VLD out.
// Optional: define MUX_SCAN_PARITY_EN to add OUT_PAR, the even parity of the captured sample.
module mux_scan_n #(
    parameter int N_CH  = 8,
    parameter int W     = 8,
    parameter int DWELL = 4
) (
    input  logic         CLK,
    input  logic         RST_N,
    mux_scan_n_if.slave  bus
);
    localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    // The state register doubles as the registered copy of MODE.
    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [W-1:0]      data_q, data_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic              vld_q, vld_d;
`ifdef MUX_SCAN_PARITY_EN
    logic              par_q, par_d;
`endif

    logic              cap;
    logic              scan_entry;
    logic [SEL_W-1:0]  ptr_base;
    logic [DCNT_W-1:0] dcnt_base;
    logic [SEL_W-1:0]  selc;
    logic [W-1:0]      mux_dat;

    // Mode, capture and scan pointer. The mode input acts in the cycle it
    // changes, so selection follows state_d rather than state_q.
    always_comb begin
        state_d    = bus.MODE ? SCAN : MANUAL;
        scan_entry = (state_d == SCAN) && (state_q == MANUAL);
        cap        = bus.EN && (!vld_q || bus.OUT_RDY);

        // On scan entry the pointer restarts at channel 0 even for a capture in that cycle.
        ptr_base   = scan_entry ? '0 : ptr_q;
        dcnt_base  = scan_entry ? '0 : dcnt_q;
        selc       = (state_d == SCAN) ? ptr_base : bus.S;

        ptr_d      = ptr_base;
        dcnt_d     = dcnt_base;
        if (cap && (state_d == SCAN)) begin
            if (dcnt_base == DCNT_W'(DWELL - 1)) begin
                dcnt_d = '0;
                ptr_d  = (ptr_base == SEL_W'(N_CH - 1)) ? '0 : ptr_base + SEL_W'(1);
            end else begin
                dcnt_d = dcnt_base + DCNT_W'(1);
            end
        end
    end

    // Select with no match for out-of-range codes, so they read as zero.
    always_comb begin
        mux_dat = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (selc == SEL_W'(k)) begin
                mux_dat = bus.I[k*W +: W];
            end
        end
    end

    // Output stage: load on capture, drop valid on a transfer with nothing new.
    always_comb begin
        data_d = data_q;
        ch_d   = ch_q;
        vld_d  = vld_q;
`ifdef MUX_SCAN_PARITY_EN
        par_d  = par_q;
`endif
        if (cap) begin
            data_d = mux_dat;
            ch_d   = selc;
            vld_d  = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
            par_d  = ^mux_dat;
`endif
        end else if (vld_q && bus.OUT_RDY) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= MANUAL;
            ptr_q   <= '0;
            dcnt_q  <= '0;
            data_q  <= '0;
            ch_q    <= '0;
            vld_q   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dcnt_q  <= dcnt_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            vld_q   <= vld_d;
`ifdef MUX_SCAN_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.OUT_DATA = data_q;
    assign bus.OUT_CH   = ch_q;
    assign bus.OUT_VLD  = vld_q;
`ifdef MUX_SCAN_PARITY_EN
    assign bus.OUT_PAR  = par_q;
`endif

endmodule

// File: doc/mux_scan_n.md
Name: mux_scan_n

Overview:
- Parametrised N-channel, W-bit multiplexer with a registered output stage and a valid/ready handshake.
- Two modes. Manual: the channel comes from S. Auto-scan: an internal pointer walks channels 0..N_CH-1, staying on each channel for DWELL accepted samples.
- Sits between parallel sensor or data lanes and a single downstream consumer. It replaces hard-wired tree muxes where backpressure and scanning are needed.

Parameters:
- N_CH, 8, number of input channels (>=1; need not be a power of 2).
- W, 8, bits per channel.
- DWELL, 4, accepted samples per channel in scan mode before the pointer advances (>=1).
- SEL_W, derived: max(1, clog2(N_CH)). Localparam; not overridable.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- I  in  N_CH*W  packed channel data; channel k at I[k*W +: W].
- S  in  SEL_W  manual channel select.
- MODE  in  1  0 = manual, 1 = auto-scan.
- EN  in  1  sample request.
- OUT_RDY  in  1  downstream ready.
- OUT_DATA  out  W  registered sample.
- OUT_CH  out  SEL_W  channel index of OUT_DATA.
- OUT_VLD  out  1  OUT_DATA/OUT_CH valid.

Behaviour:
- Reset is asynchronous, active-low: one clock, CLK; asynchronous active-low reset RST_N. While RST_N=0: OUT_DATA=0, OUT_CH=0, OUT_VLD=0, PTR=0, DCNT=0, MODE_Q=0 (FSM in MANUAL). Deassertion is synchronised externally.
- FSM states: MANUAL and SCAN.
  - MANUAL->SCAN when MODE=1. SCAN->MANUAL when MODE=0. The transition takes effect in the same cycle MODE changes.
  - On entry to SCAN (MODE=1 and MODE_Q=0): PTR<=0 and DCNT<=0. A capture in that cycle uses channel 0.
- Capture condition: CAP = EN && (!OUT_VLD || OUT_RDY).
  - On CAP, OUT_DATA and OUT_CH load at the next edge and OUT_VLD<=1. Latency is 1 cycle from EN to OUT_VLD.
- Selected channel SELC: S in MANUAL; PTR in SCAN (0 on the scan-entry cycle).
- Out-of-range select (S >= N_CH, MANUAL only): OUT_DATA loads 0 and OUT_CH loads S. No X propagation.
- Handshake:
  - Transfer occurs when OUT_VLD && OUT_RDY.
  - Transfer without CAP: OUT_VLD<=0.
  - OUT_VLD && !OUT_RDY: OUT_DATA, OUT_CH and OUT_VLD hold stable and EN is ignored (no capture, no pointer movement).
  - Simultaneous transfer and CAP: back-to-back, OUT_VLD stays 1 with the new data. Full throughput is 1 sample/cycle.
- Scan pointer: advances only on CAP in SCAN.
  - DCNT counts captures on the current channel.
  - When DCNT==DWELL-1 on CAP: DCNT<=0 and PTR<=(PTR==N_CH-1)?0:PTR+1. Otherwise DCNT<=DCNT+1.
  - DWELL=1 advances PTR on every capture. N_CH=1 keeps PTR at 0.
- MODE_Q registers MODE every cycle.
- MANUAL mode does not change PTR or DCNT. They are reset only by scan entry or RST_N.
- A mode change while OUT_VLD && !OUT_RDY updates the FSM/MODE_Q but does not alter held output. The scan-entry reset of PTR/DCNT still applies.
- Reset mid-operation: all state clears immediately and any held sample is discarded.

Optional Feature:
- Macro MUX_SCAN_PARITY_EN.
- Defined: adds output port OUT_PAR (1 bit), registered alongside OUT_DATA.
  - OUT_PAR = even parity (XOR reduction) of the captured OUT_DATA. Out-of-range captures give OUT_PAR=0. Reset value 0.
  - Held and transferred exactly like OUT_DATA.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset/latency: defaults, I channel k = 8'h10+k, MODE=0, S=5, EN=1 one cycle, OUT_RDY=1. Expect OUT_VLD=0 during reset; next edge OUT_DATA=8'h15, OUT_CH=5, OUT_VLD=1; following cycle OUT_VLD=0.
- Backpressure: capture S=2 with OUT_RDY=0, hold EN=1 and change S to 3 for 5 cycles. Expect OUT_DATA=8'h12, OUT_CH=2 stable. Then raise OUT_RDY: next edge OUT_DATA=8'h13.
- Scan wrap: MODE=1, EN=1, OUT_RDY=1 for 32 cycles. Expect OUT_CH sequence 0,0,0,0,1,1,1,1,...,7,7,7,7, then 0 again, with OUT_DATA=8'h10+OUT_CH.
- Scan re-entry: scan 6 samples (PTR=1, DCNT=2), MODE=0 for 3 cycles, MODE=1. Expect the first scan capture on channel 0 and 4 captures before channel 1.
- Out-of-range: N_CH=6 (SEL_W=3), MANUAL, S=7, EN=1. Expect OUT_DATA=0, OUT_CH=7, OUT_VLD=1. Async reset asserted mid-cycle while OUT_VLD=1: OUT_VLD drops immediately, without waiting for CLK.
- Parity (MUX_SCAN_PARITY_EN defined): capture channel with data 8'h07. Expect OUT_PAR=1. Data 8'h03: expect OUT_PAR=0.
